// File: rtl/gray_code_decoder_subsystem_if.sv
// Gray decoder link interface.
// Groups the input handshake (in_valid/gray_in/in_ready), the output handshake
// (out_valid/out_ready) with the decoded word and step flags, the error counter and
// a debug view of the reference-tracking FSM.
// Handshake: a word moves across a side on every rising clk edge where its valid and
// ready are both 1; valid may not depend on ready, and a source that raises valid holds
// its data stable until that transfer happens.
//   slave  : the decoder (consumes in_*, produces out_*)
//   master : the driving environment
interface gray_code_decoder_subsystem_if #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic [WIDTH-1:0]     gray_in;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     bin_out;
  logic                 step_up;
  logic                 step_dn;
  logic                 step_err;
  logic [CNT_WIDTH-1:0] err_cnt;
  logic                 dbg_state;  // 0 = no reference word yet, 1 = tracking

  modport slave (
    input  in_valid, gray_in, out_ready,
    output in_ready, out_valid, bin_out, step_up, step_dn, step_err, err_cnt, dbg_state
  );

  modport master (
    output in_valid, gray_in, out_ready,
    input  in_ready, out_valid, bin_out, step_up, step_dn, step_err, err_cnt, dbg_state
  );
endinterface

// File: rtl/gray_code_decoder_subsystem.sv
// Gray-to-binary decoder with one registered output stage.
// Decodes each accepted Gray word, compares it with the previously accepted word and
// reports the step as up (+1), down (-1), repeat (0, no flag) or error (anything else,
// counted in a saturating counter). The very first word after reset has no reference
// and raises no flag.
// Ports:
//   clk    : rising-edge system clock
//   reset  : asynchronous, active-high reset
//   bus    : slave side of gray_code_decoder_subsystem_if (handshakes, data, flags,
//            err_cnt, dbg_state)
module gray_code_decoder_subsystem #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  gray_code_decoder_subsystem_if.slave  bus
);

  typedef enum logic {
    NO_REF = 1'b0,
    TRACK  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] STEP_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_NEG = '1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     bin_q, prev_q;
  logic                 valid_q, up_q, dn_q, err_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [WIDTH-1:0]     bin_new;
  logic [WIDTH-1:0]     diff;
  logic                 in_ready;
  logic                 accept;
  logic                 up_d, dn_d, err_d;

  // Ready depends only on the output register, never on in_valid.
  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_new = '0;
    bin_new[WIDTH-1] = bus.gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin_new[i] = bin_new[i+1] ^ bus.gray_in[i];
    end
  end

  // Modular step from the previous accepted word.
  assign diff = bin_new - prev_q;

  always_comb begin
    state_d = state_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      case (state_q)
        NO_REF: state_d = TRACK;
        TRACK: begin
          if (diff == STEP_ONE)      up_d  = 1'b1;
          else if (diff == STEP_NEG) dn_d  = 1'b1;
          else if (diff != '0)       err_d = 1'b1;
        end
        default: state_d = NO_REF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NO_REF;
      bin_q   <= '0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bin_q   <= bin_new;
        prev_q  <= bin_new;
        valid_q <= 1'b1;
        up_q    <= up_d;
        dn_q    <= dn_d;
        err_q   <= err_d;
        // One increment per accepted error word; stalls cannot re-count it.
        if (err_d && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.bin_out   = bin_q;
  assign bus.step_up   = up_q;
  assign bus.step_dn   = dn_q;
  assign bus.step_err  = err_q;
  assign bus.err_cnt   = cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_gray_code_decoder_subsystem.sv
module tb_gray_code_decoder_subsystem;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  gray_code_decoder_subsystem_if #(.WIDTH(4), .CNT_WIDTH(8)) bus ();

  gray_code_decoder_subsystem #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Expected word layout: {out_valid, bin[3:0], up, dn, err, err_cnt[7:0]}
  logic [15:0] exp_q[$];
  bit          m_have_ref;
  int          m_prev;
  int          m_cnt;

  task automatic model_reset();
    m_have_ref = 0;
    m_prev     = 0;
    m_cnt      = 0;
    exp_q.delete();
  endtask

  // Decode by searching for the binary value whose Gray image matches.
  function automatic logic [15:0] model_word(input logic [3:0] g);
    int   b;
    int   d;
    logic up, dn, er;
    b  = 0;
    up = 1'b0;
    dn = 1'b0;
    er = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (((c ^ (c >> 1)) & 15) == int'(g)) b = c;
    end
    if (m_have_ref) begin
      d  = (b - m_prev + 16) % 16;
      up = (d == 1);
      dn = (d == 15);
      er = (d != 0) && !up && !dn;
      if (er && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    m_have_ref = 1;
    m_prev     = b;
    return {1'b1, 4'(b), up, dn, er, 8'(m_cnt)};
  endfunction

  function automatic logic [3:0] to_gray(input int b);
    int v;
    v = b & 15;
    return 4'(v ^ (v >> 1));
  endfunction

  function automatic logic [15:0] observed();
    return {bus.out_valid, bus.bin_out, bus.step_up, bus.step_dn, bus.step_err, bus.err_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.gray_in   = 4'h0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one word for one cycle; the model records its expectation.
  task automatic drive_word(input logic [3:0] g);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.gray_in  = g;
    exp_q.push_back(model_word(g));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.gray_in  = 4'($urandom_range(0, 15));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (observed() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", observed(), 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_gray_sweep();
    logic [15:0] e;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive_word(to_gray(i));
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e) begin
        tests_failed++;
        $display("FAIL gray_sweep[%0d]: got %h expected %h", i, observed(), e);
      end
      if (i > 0) begin
        tests_run++;
        if (bus.step_up !== 1'b1 || bus.bin_out !== 4'(i)) begin
          tests_failed++;
          $display("FAIL sweep_up[%0d]: got up=%b bin=%h expected up=1 bin=%h",
                   i, bus.step_up, bus.bin_out, 4'(i));
        end
      end
    end
    tests_run++;
    if (bus.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL sweep_err_cnt: got %0d expected 0", bus.err_cnt);
    end
  endtask

  task automatic test_wrap_down();
    logic [3:0] codes [4];
    logic [2:0] flags [4];
    logic [15:0] e;
    codes[0] = 4'b1000; codes[1] = 4'b0000; codes[2] = 4'b1000; codes[3] = 4'b1001;
    flags[0] = 3'b000;  flags[1] = 3'b100;  flags[2] = 3'b010;  flags[3] = 3'b010;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_word(codes[i]);
      e = exp_q.pop_front();
      tests_run++;
      if (observed() !== e || {bus.step_up, bus.step_dn, bus.step_err} !== flags[i]) begin
        tests_failed++;
        $display("FAIL wrap_down[%0d]: got %h expected %h (flags %b)", i, observed(), e, flags[i]);
      end
    end
  endtask

  task automatic test_error_step();
    logic [15:0] e;
    apply_reset();
    drive_word(4'b0000);
    void'(exp_q.pop_front());
    drive_word(4'b0100);
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e || bus.step_err !== 1'b1 || bus.err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL error_step: got %h expected %h", observed(), e);
    end
    drive_word(4'b0100);
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e || {bus.step_up, bus.step_dn, bus.step_err} !== 3'b000 ||
        bus.err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL error_repeat: got %h expected %h", observed(), e);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    int          xfers;
    apply_reset();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.gray_in   = 4'b0011;
    exp_q.push_back(model_word(4'b0011));
    e = exp_q.pop_front();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0 || observed() !== e || bus.bin_out !== 4'b0010) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b %h expected rdy=0 %h",
                 c, bus.in_ready, observed(), e);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (bus.out_valid && bus.out_ready) xfers++;
      @(negedge clk);
    end
    tests_run++;
    if (xfers !== 1) begin
      tests_failed++;
      $display("FAIL backpressure_xfers: got %0d expected 1", xfers);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] e;
    int          errs;
    errs = 0;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      drive_word((i % 2 == 0) ? 4'b0000 : 4'b0100);
      e = exp_q.pop_front();
      if (observed() !== e) errs++;
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL saturation_words: got %0d mismatching words expected 0", errs);
    end
    tests_run++;
    if (bus.err_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL saturation_cnt: got %0d expected 255", bus.err_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [15:0] e;
    apply_reset();
    drive_word(4'b0000);
    void'(exp_q.pop_front());
    drive_word(4'b0100);
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b cnt=%0d expected valid=0 cnt=0",
               bus.out_valid, bus.err_cnt);
    end
    @(negedge clk);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    drive_word(4'b0100);
    e = exp_q.pop_front();
    tests_run++;
    if (observed() !== e || bus.step_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_ref: got %h expected %h", observed(), e);
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    int          b;
    int          errs;
    errs = 0;
    b    = 0;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.gray_in  = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
        if (bus.out_valid !== 1'b0) errs++;
      end else begin
        case ($urandom_range(0, 3))
          0: b = b + 1;
          1: b = b + 15;
          2: b = b;
          default: b = $urandom_range(0, 15);
        endcase
        b = b & 15;
        drive_word(to_gray(b));
        e = exp_q.pop_front();
        if (observed() !== e) begin
          errs++;
          $display("FAIL random[%0d]: got %h expected %h", i, observed(), e);
        end
      end
    end
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL random_total: got %0d bad cycles expected 0", errs);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.gray_in   = 4'h0;
    bus.out_ready = 1'b1;
    model_reset();
    test_reset();
    test_gray_sweep();
    test_wrap_down();
    test_error_step();
    test_backpressure();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
